// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor F = A - B, one bit per clock, LSB first.
// A start/busy/done handshake loads the operands; Bo/OF/ZF flags accompany each result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             Bo,
    output logic             OF,
    output logic             ZF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             bo_q, bo_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;

    logic             a_i, b_i, diff, br_nxt;
    logic [WIDTH-1:0] res;

    // The minuend register doubles as the result register: each difference
    // bit enters at the MSB as the consumed minuend bit leaves at the LSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        bo_d    = bo_q;
        of_d    = of_q;
        zf_d    = zf_q;

        a_i    = a_q[0];
        b_i    = b_q[0];
        diff   = a_i ^ b_i ^ br_q;
        br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
        res    = {diff, a_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = res;
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // On the last step a_i/b_i are the operand sign bits.
                    f_d     = res;
                    bo_d    = br_nxt;
                    of_d    = (a_i != b_i) && (diff != a_i);
                    zf_d    = (res == '0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= '0;
            bo_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            done_q  <= done_d;
            f_q     <= f_d;
            bo_q    <= bo_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
        end
    end

    // Operand shift registers carry no state that matters outside a run.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign F    = f_q;
    assign Bo   = bo_q;
    assign OF   = of_q;
    assign ZF   = zf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8, plus an exhaustive sweep of a WIDTH=3 instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A, B;
    logic       busy, done, Bo, OF, ZF;
    logic [7:0] F;

    logic       start3;
    logic [2:0] A3, B3;
    logic       busy3, done3, Bo3, OF3, ZF3;
    logic [2:0] F3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .F(F), .Bo(Bo), .OF(OF), .ZF(ZF)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(A3), .B(B3),
        .busy(busy3), .done(done3), .F(F3), .Bo(Bo3), .OF(OF3), .ZF(ZF3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ef, input logic ebo, input logic eof, input logic ezf);
        int lat;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_F"},  32'(F),  32'(ef));
        chk({tag, "_Bo"}, 32'(Bo), 32'(ebo));
        chk({tag, "_OF"}, 32'(OF), 32'(eof));
        chk({tag, "_ZF"}, 32'(ZF), 32'(ezf));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_F_held"}, 32'(F), 32'(ef));
    endtask

    initial begin
        int early;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        start3 = 1'b0; A3 = '0; B3 = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_F",    32'(F),    32'd0);
        chk("rst_Bo",   32'(Bo),   32'd0);
        chk("rst_OF",   32'(OF),   32'd0);
        chk("rst_ZF",   32'(ZF),   32'd0);

        do_op("5m3",   8'd5,   8'd3,   8'h02, 1'b0, 1'b0, 1'b0);
        do_op("3m5",   8'd3,   8'd5,   8'hFE, 1'b1, 1'b0, 1'b0);
        do_op("80m01", 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0);
        do_op("55m55", 8'h55,  8'h55,  8'h00, 1'b0, 1'b0, 1'b1);
        do_op("7Fm80", 8'h7F,  8'h80,  8'hFF, 1'b1, 1'b1, 1'b0);

        // start held high with operands changing every cycle
        A = 8'd5; B = 8'd3; start = 1'b1;
        tick();
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            A = 8'(i * 37);
            B = 8'(i * 91);
            tick();
            if (i < 8 && done) early++;
        end
        chk("hold_early_done", 32'(early), 32'd0);
        chk("hold1_done", 32'(done), 32'd1);
        chk("hold1_F",    32'(F),    32'h02);
        A = 8'h10; B = 8'h20;
        tick();
        chk("hold_b2b_busy", 32'(busy), 32'd1);
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            A = 8'(i * 53);
            B = 8'(i * 29);
            if (i == 8) start = 1'b0;
            tick();
            if (i < 8 && done) early++;
        end
        chk("hold2_early_done", 32'(early), 32'd0);
        chk("hold2_done", 32'(done), 32'd1);
        chk("hold2_F",    32'(F),    32'hF0);
        chk("hold2_Bo",   32'(Bo),   32'd1);
        tick();
        chk("hold_stop_busy", 32'(busy), 32'd0);

        // reset in the middle of a run
        A = 8'h10; B = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_F",    32'(F),    32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        early = 0;
        repeat (10) begin
            tick();
            if (done) early++;
        end
        chk("midrst_no_done", 32'(early), 32'd0);
        do_op("post_rst", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

        // exhaustive WIDTH=3 sweep, result packed as {latency, Bo, OF, ZF, F}
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                logic [3:0] diff;
                logic       eof;
                int         lat;
                diff = {1'b0, 3'(a)} - {1'b0, 3'(b)};
                eof  = (a[2] != b[2]) && (diff[2] != a[2]);
                A3 = 3'(a);
                B3 = 3'(b);
                start3 = 1'b1;
                tick();
                start3 = 1'b0;
                lat = 0;
                do begin
                    tick();
                    lat++;
                end while (!done3 && lat < 10);
                chk($sformatf("w3_%0d_%0d", a, b),
                    {20'd0, 6'(lat), Bo3, OF3, ZF3, F3},
                    {20'd0, 6'd3, diff[3], eof, (diff[2:0] == 3'd0), diff[2:0]});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
